// File: rtl/shift_mix_cols.sv
// shift_mix_cols: AES ShiftRows then iterative MixColumns, COLS_PER_CYCLE columns per clock.
// Define SHIFT_MIX_INV_EN to add the inverse (InvMixColumns + InvShiftRows) path selected by inv_i.
module shift_mix_cols #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         last_i,
  input  logic         inv_i,
  input  logic [127:0] state_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] state_o
);
  typedef enum logic [1:0] {IDLE, BUSY, FIN} fsm_t;
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  fsm_t fsm_q, fsm_d;
  logic [127:0] work_q, work_d, out_q, out_d;
  logic [1:0] col_q, col_d;
  logic done_q, done_d, inv_in, inv_sel;
  logic [15:0] coef;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{k[0]}} & x) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction
  // k holds the four column coefficients, first-row order, one nibble each
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic [15:0] k);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        o[31-8*i -: 8] = o[31-8*i -: 8] ^ gmul(a[31-8*((i+j)%4) -: 8], k[15-4*j -: 4]);
    return o;
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*(inv ? (c-r+4)%4 : (c+r)%4)) -: 8];
    return o;
  endfunction
`ifdef SHIFT_MIX_INV_EN
  logic inv_q, inv_d;
  assign inv_in  = inv_i;
  assign inv_sel = inv_q;
  assign coef    = inv_q ? 16'hebd9 : 16'h2311;
  always_comb inv_d = (fsm_q == IDLE && en_i) ? inv_i : inv_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) inv_q <= 1'b0;
    else inv_q <= inv_d;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign inv_in     = 1'b0;
  assign inv_sel    = 1'b0;
  assign coef       = 16'h2311;
`endif
  always_comb begin
    fsm_d  = fsm_q;
    work_d = work_q;
    col_d  = col_q;
    out_d  = out_q;
    done_d = 1'b0;
    unique case (fsm_q)
      IDLE: if (en_i) begin
        work_d = inv_in ? state_i : shift_rows(state_i, 1'b0);
        col_d  = 2'd0;
        fsm_d  = last_i ? FIN : BUSY;
      end
      BUSY: begin
        for (int j = 0; j < 4; j++)
          if (j >= int'(col_q) && j < int'(col_q) + COLS_PER_CYCLE)
            work_d[127-32*j -: 32] = mix_col(work_q[127-32*j -: 32], coef);
        col_d = col_q + STEP;
        fsm_d = (int'(col_q) + COLS_PER_CYCLE >= 4) ? FIN : BUSY;
      end
      FIN: begin
        out_d  = inv_sel ? shift_rows(work_q, 1'b1) : work_q;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      fsm_q  <= IDLE;
      work_q <= '0;
      col_q  <= 2'd0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      work_q <= work_d;
      col_q  <= col_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  assign busy_o  = fsm_q != IDLE;
  assign done_o  = done_q;
  assign state_o = out_q;
endmodule
